audio_frame_buffer: RTL and testbench
=====================================

# audio_frame_buffer

Ping-pong frame buffer that collects audio samples arriving at the 48 kHz sample-clock rate into 480-sample blocks and presents each completed block to the autocorrelation engine for random-access reads. It is the producer end of the block interface: while the engine processes one bank, the next block fills the other bank. It also synchronizes the slow sample clock into the `Clk` domain and flags overruns when the consumer falls behind.

## Interface
- `BLOCK_LEN`, 480, samples per block; range 2..512.
- `DATA_W`, 32, stored sample width.
- `Clk` in 1, system clock; all logic on its rising edge.
- `Reset_n` in 1, synchronous active-low reset.
- `sample_clk` in 1, asynchronous 48 kHz sample strobe level (BCLK-derived); each rising edge delivers one sample.
- `sample_in` in `DATA_W`, sample word, stable from 1 `Clk` before to 4 `Clk` after each `sample_clk` rising edge.
- `blk_ready` out 1, a complete block is owned by the consumer and readable.
- `blk_done` in 1, single-cycle pulse; consumer releases the read bank.
- `rd_addr` in 9, read index into the ready block.
- `rd_data` out `DATA_W`, registered read data.
- `wr_cnt` out 9, samples written so far into the fill bank.
- `overrun` out 1, sticky; a block was discarded.

## Operation
- Two banks, A and B, each `BLOCK_LEN` x `DATA_W`. `wr_bank` selects the fill bank; the other bank is the read bank.
- FSM states:
  - EMPTY: filling, nothing presented.
  - READY: filling, read bank presented, `blk_ready`=1.
- Sample write: on each detected `sample_clk` rising edge, store `sample_in` at `fill[wr_cnt]` and increment `wr_cnt`.
- Block complete, i.e. a write at `wr_cnt`=`BLOCK_LEN`-1:
  - `wr_cnt`→0 in all cases.
  - In EMPTY: toggle `wr_bank` and go to READY.
  - In READY without `blk_done`: set `overrun`, keep `wr_bank`, stay in READY. The just-filled block is discarded and is overwritten by the next samples.
- `blk_done` in READY with no completion in the same cycle: go to EMPTY. `blk_done` in EMPTY is ignored.
- Simultaneous `blk_done` and completion in READY: the release applies first. `wr_bank` toggles, the state stays READY, `blk_ready` stays 1 (new block), and `overrun` is not set.
- Reads:
  - `rd_data` <= `read[rd_addr]` every cycle, regardless of `blk_ready`.
  - `rd_addr` >= `BLOCK_LEN` gives 0.
- `overrun` clears only on reset.

## Timing
- Reset values:
  - `blk_ready`=0, `wr_cnt`=0, `overrun`=0, `rd_data`=0.
  - State EMPTY, `wr_bank`=A, sync flops 0.
  - Bank RAM contents are not cleared.
- Sample path latency: a `sample_clk` rising edge passes 2 sync flops plus 1 edge-detect flop. The RAM write and the `wr_cnt` update become visible 3 `Clk` edges after the first flop samples the high level.
- `blk_ready` rises on the `Clk` edge after the completing write.
- `blk_ready` falls on the edge after `blk_done`.
- Read latency: 1 cycle from `rd_addr` to `rd_data`. After a bank swap, `rd_data` reflects the new read bank from the next cycle.
- Reset asserted mid-block: the partial block is discarded and the next sample goes to A[0].

## Configuration
- `FRAME_SIGN_EXT24_EN`
  - Defined: only `sample_in[23:0]` is used. It is sign-extended to `DATA_W`, so 24'h800000 is stored as 32'hFF800000.
  - Undefined: `sample_in` is stored verbatim.

## Structure
- Package `audio_frame_pkg`:
  - `BLOCK_LEN`, `DATA_W`, address width 9.
  - FSM state enum {EMPTY, READY}.
  - `sample_t` typedef.
- Sub-module `sample_edge_sync`: 2-flop synchronizer plus rising-edge detect. It takes `Clk`, `Reset_n` and the async level, and outputs a 1-cycle `sample_stb`.
- Banks are inferred as two arrays selected by `wr_bank`.

## Test plan
- Reset, then 480 `sample_clk` edges with value i-130 -> `blk_ready`=1 one cycle after the 480th write. `rd_addr`=0 returns 0xFFFFFF7E; `rd_addr`=479 returns 349.
- With a block ready, 200 more samples -> `wr_cnt`=200, `blk_ready` stays 1, read data unchanged.
- Block ready, no `blk_done`, another 480 samples -> `overrun`=1 and `blk_ready`=1. Reads still show the first block; the second block is lost.
- `blk_done` pulsed in the same cycle as the 480th write of block 2 -> `blk_ready` stays 1, reads show block 2, `overrun`=0.
- `Reset_n`=0 for 1 cycle after 100 samples -> `wr_cnt`=0, `blk_ready`=0. The next sample is written to A[0].
- With `FRAME_SIGN_EXT24_EN` defined, `sample_in`=32'h00800001 -> stored 32'hFF800001. Without the macro -> stored 32'h00800001.

Source files
------------

// File: rtl/audio_frame_pkg.sv
// audio_frame_pkg: shared constants and types for the audio frame buffer
package audio_frame_pkg;
  localparam int BLOCK_LEN = 480;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  typedef enum logic {EMPTY, READY} state_t;
  typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/audio_frame_buffer_sync.sv
// sample_edge_sync: 2-flop synchronizer plus rising-edge detect, one-cycle sample_stb
module sample_edge_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic sample_clk,
  output logic sample_stb
);
  logic [2:0] syncQ;
  always_ff @(posedge Clk)
    syncQ <= !Reset_n ? 3'b000 : {syncQ[1:0], sample_clk};
  assign sample_stb = syncQ[1] & ~syncQ[2];
endmodule

// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: ping-pong block buffer feeding the autocorrelation engine
// FRAME_SIGN_EXT24_EN: store sample_in[23:0] sign-extended instead of verbatim
module audio_frame_buffer
  import audio_frame_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sample_clk,
  input  sample_t           sample_in,
  output logic              blk_ready,
  input  logic              blk_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output sample_t           rd_data,
  output logic [ADDR_W-1:0] wr_cnt,
  output logic              overrun
);
  state_t state, stateNext;
  logic wrBank, wrBankNext, overrunNext, sampleStb, blockDone;
  logic [ADDR_W-1:0] wrCntNext;
  sample_t sampleVal;
  sample_t bankA [BLOCK_LEN];
  sample_t bankB [BLOCK_LEN];
  sample_edge_sync u_sync (
    .Clk(Clk), .Reset_n(Reset_n), .sample_clk(sample_clk), .sample_stb(sampleStb)
  );
`ifdef FRAME_SIGN_EXT24_EN
  assign sampleVal = sample_t'($signed(sample_in[23:0]));
`else
  assign sampleVal = sample_in;
`endif
  assign blockDone = sampleStb && int'(wr_cnt) == BLOCK_LEN - 1;
  assign blk_ready = state == READY;
  // a release coinciding with completion frees the read bank before the swap
  always_comb begin
    stateNext = state;
    wrBankNext = wrBank;
    overrunNext = overrun;
    wrCntNext = sampleStb ? (blockDone ? '0 : wr_cnt + 1'b1) : wr_cnt;
    if (blockDone && (state == EMPTY || blk_done)) begin
      wrBankNext = ~wrBank;
      stateNext = READY;
    end else if (blockDone) overrunNext = 1'b1;
    else if (blk_done) stateNext = EMPTY;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= EMPTY;
      wrBank <= 1'b0;
      wr_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      state <= stateNext;
      wrBank <= wrBankNext;
      wr_cnt <= wrCntNext;
      overrun <= overrunNext;
    end
  end
  always_ff @(posedge Clk) begin
    if (sampleStb && wrBank) bankB[wr_cnt] <= sampleVal;
    if (sampleStb && !wrBank) bankA[wr_cnt] <= sampleVal;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) rd_data <= '0;
    else rd_data <= int'(rd_addr) >= BLOCK_LEN ? '0 : wrBank ? bankA[rd_addr] : bankB[rd_addr];
  end
endmodule

// File: tb/tb_audio_frame_buffer.sv
// tb_audio_frame_buffer: randomized directed bench against a per-sample block model
module tb_audio_frame_buffer;
  import audio_frame_pkg::*;
  logic Clk = 0, Reset_n = 0, sample_clk = 0, blk_done = 0;
  sample_t sample_in = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  sample_t rd_data;
  logic blk_ready, overrun;
  logic [ADDR_W-1:0] wr_cnt;
  int checks = 0, errors = 0;
  sample_t mem [2][BLOCK_LEN];
  int mFill = 0, mCnt = 0;
  bit mReady = 0, mOverrun = 0;

  audio_frame_buffer dut (
    .Clk(Clk), .Reset_n(Reset_n), .sample_clk(sample_clk), .sample_in(sample_in),
    .blk_ready(blk_ready), .blk_done(blk_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_cnt(wr_cnt), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  function automatic sample_t stored(sample_t v);
`ifdef FRAME_SIGN_EXT24_EN
    return {{8{v[23]}}, v[23:0]};
`else
    return v;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // block-level rules: one call per delivered sample
  task automatic modelSample(sample_t v, bit done);
    mem[mFill][mCnt] = stored(v);
    if (mCnt == BLOCK_LEN - 1) begin
      mCnt = 0;
      if (!mReady) begin mFill ^= 1; mReady = 1; end
      else if (done) mFill ^= 1;
      else mOverrun = 1;
    end else mCnt++;
  endtask

  task automatic sendSample(sample_t v, bit done);
    @(negedge Clk);
    sample_in = v;
    @(negedge Clk);
    sample_clk = 1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    check("wr_cnt_before_write", 32'(wr_cnt), 32'(mCnt));
    if (done) blk_done = 1;
    @(posedge Clk);
    modelSample(v, done);
    @(negedge Clk);
    blk_done = 0;
    check("wr_cnt_after_write", 32'(wr_cnt), 32'(mCnt));
    repeat (3) @(negedge Clk);
    sample_clk = 0;
    repeat ($urandom_range(2, 4)) @(negedge Clk);
  endtask

  task automatic sendRandom(int n);
    for (int i = 0; i < n; i++) sendSample($urandom, 0);
  endtask

  task automatic checkStatus(string tag);
    check({tag, "_blk_ready"}, 32'(blk_ready), 32'(mReady));
    check({tag, "_overrun"}, 32'(overrun), 32'(mOverrun));
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(mCnt));
  endtask

  task automatic checkRead(int addr);
    @(negedge Clk);
    rd_addr = addr[ADDR_W-1:0];
    @(negedge Clk);
    check("rd_data", rd_data, addr >= BLOCK_LEN ? 32'h0 : mem[mFill ^ 1][addr]);
  endtask

  task automatic readSweep(int n);
    checkRead(0);
    checkRead(BLOCK_LEN - 1);
    checkRead(BLOCK_LEN);
    checkRead(511);
    for (int i = 0; i < n; i++) checkRead($urandom_range(0, 511));
  endtask

  task automatic pulseDone();
    @(negedge Clk);
    blk_done = 1;
    @(negedge Clk);
    blk_done = 0;
    mReady = 0;
    @(negedge Clk);
    checkStatus("after_done");
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset_n = 0;
    @(negedge Clk);
    mCnt = 0; mFill = 0; mReady = 0; mOverrun = 0;
    check("reset_rd_data", rd_data, 32'h0);
    checkStatus("reset");
    Reset_n = 1;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("por_rd_data", rd_data, 32'h0);
    checkStatus("por");
    Reset_n = 1;
    for (int i = 0; i < BLOCK_LEN; i++) sendSample(sample_t'(i - 130), 0);
    @(negedge Clk);
    checkStatus("block1");
    checkRead(0);
    check("block1_first", rd_data, 32'hFFFFFF7E);
    checkRead(BLOCK_LEN - 1);
    check("block1_last", rd_data, 32'd349);
    readSweep(20);
    sendRandom(200);
    checkStatus("partial200");
    readSweep(10);
    sendRandom(BLOCK_LEN - 200);
    checkStatus("overrun");
    readSweep(10);
    sendRandom(100);
    doReset();
    sendSample(32'h00800001, 0);
    sendRandom(BLOCK_LEN - 1);
    checkStatus("after_reset_block");
    checkRead(0);
    check("sign_ext_at_A0", rd_data, stored(32'h00800001));
    readSweep(10);
    sendRandom(BLOCK_LEN - 1);
    sendSample($urandom, 1);
    checkStatus("done_at_completion");
    readSweep(20);
    pulseDone();
    pulseDone();
    sendRandom(BLOCK_LEN);
    checkStatus("refill");
    readSweep(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
